universal_shift_register: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and clear.
REQ-002 Parameter: WIDTH, default 4, register width in bits; legal values are 2 and above.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: clear  input  1  asynchronous active-low reset; 0 clears the register.
REQ-005 Port: s  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 Port: sisr  input  1  serial data input for shift right; enters at the MSB.
REQ-007 Port: sisl  input  1  serial data input for shift left; enters at the LSB.
REQ-008 Port: pin  input  WIDTH  parallel load data.
REQ-009 Port: q  output  WIDTH  register contents, driven directly from flops.

Function
REQ-010 The block SHALL hold a single WIDTH-bit register q, updated only on the rising edge of clk while clear=1.
REQ-011 With s=00 (hold), q SHALL keep its value.
REQ-012 With s=01 (shift right), q SHALL become {sisr, q[WIDTH-1:1]}; the old q[0] is discarded.
REQ-013 With s=10 (shift left), q SHALL become {q[WIDTH-2:0], sisl}; the old q[WIDTH-1] is discarded.
REQ-014 With s=11 (parallel load), q SHALL become pin.
REQ-015 Each operation SHALL take effect with one-cycle latency: inputs are sampled at edge N and the result is visible on q immediately after edge N.
REQ-016 In any mode, the serial input that is not used SHALL have no effect, and pin SHALL be ignored unless s=11.
REQ-017 Mode changes between edges SHALL take effect only at the next rising edge; there SHALL be no combinational path from any input to q.
REQ-018 The block SHALL have no handshake; every enabled edge performs exactly one operation.
REQ-019 If s contains X/Z during simulation, q SHALL hold its value.

Reset
REQ-020 When clear=0, q SHALL go to all zeros immediately, independent of clk.
REQ-021 While clear=0, clock edges SHALL be ignored and q SHALL stay 0.
REQ-022 Reset deassertion (clear 0->1) SHALL be synchronous to the next clk edge via standard flop recovery; the first operation occurs on the first rising edge with clear=1.
REQ-023 Asserting clear mid-operation (during a shift or a load) SHALL abort the operation and zero q within the same cycle.

Verification
REQ-024 Reset: clear=0 with s=11 and pin=1111 while clk toggles -> q=0000 throughout; assert clear=0 between edges while q=1010 -> q=0000 with no clock edge.
REQ-025 Parallel load: clear=1, s=11, pin=1011 -> q=1011 after one edge; then s=00 for 3 edges with pin changing -> q stays 1011.
REQ-026 Shift right: q=0000, s=01, sisr=1 for 4 edges -> q=1000, 1100, 1110, 1111; then sisr=0 for 1 edge -> q=0111.
REQ-027 Shift left: q=0000, s=10, sisl=1 for 4 edges -> q=0001, 0011, 0111, 1111; then sisl=0 for 1 edge -> q=1110.
REQ-028 Mode cycling: starting from q=0000, s steps 00, 01, 10, 11 every 100 time units with clk period 40 and random pin/sisr/sisl; each edge result is checked against a reference model built from REQ-011 to REQ-014, and there are zero mismatches.
REQ-029 Unused serial input: s=01, sisr=0, sisl toggling every cycle -> q is unaffected by sisl; s=10 with sisr toggling -> q is unaffected by sisr.

Source files
------------

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit register with hold, shift right, shift left and parallel load
// Mode is sampled on the rising edge only; q comes straight from the state flops.
module universal_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       s,
  input  logic             sisr,
  input  logic             sisl,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q
);

  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Hold is the fallback so an unknown mode select leaves the register untouched.
  always_comb begin
    q_d = q_q;
    case (s)
      MODE_SHR:  q_d = {sisr, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], sisl};
      MODE_LOAD: q_d = pin;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - scoreboard bench for universal_shift_register
// A predictor pushes the expected q at every rising edge; a monitor pops and compares just after.
module tb_universal_shift_register;
  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         clear = 1'b1;
  logic [1:0]   s     = 2'b00;
  logic         sisr  = 1'b0;
  logic         sisl  = 1'b0;
  logic [W-1:0] pin   = '0;
  logic [W-1:0] q;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model = '0;
  logic [W-1:0] exp_q[$];

  universal_shift_register #(.WIDTH(W)) dut (
    .clk  (clk),
    .clear(clear),
    .s    (s),
    .sisr (sisr),
    .sisl (sisl),
    .pin  (pin),
    .q    (q)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clear) model = '0;

  // Reference: arithmetic view of each mode; anything but a clean mode code holds.
  always @(posedge clk) begin
    if (clear !== 1'b1)       model = '0;
    else if (s === 2'b01)     model = (model >> 1) | (W'(sisr) << (W - 1));
    else if (s === 2'b10)     model = (model << 1) | W'(sisl);
    else if (s === 2'b11)     model = pin;
    exp_q.push_back(model);
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk("scoreboard", q, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] shr_exp[4];
    logic [W-1:0] shl_exp[4];
    logic [W-1:0] e;
    shr_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    shl_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    // Reset held with load requested and clock running.
    #1 clear = 1'b0; s = 2'b11; pin = 4'b1111;
    #1 chk("reset_immediate", q, 4'b0000);
    repeat (3) begin
      @(posedge clk); #1 chk("reset_hold", q, 4'b0000);
      #10 chk("reset_hold_mid", q, 4'b0000);
    end

    // Parallel load then hold with pin changing.
    @(negedge clk); clear = 1'b1; s = 2'b11; pin = 4'b1011;
    @(posedge clk); #1 chk("load", q, 4'b1011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s = 2'b00; pin = W'($urandom);
      @(posedge clk); #1 chk("hold", q, 4'b1011);
    end

    // Asynchronous clear between edges while q=1010.
    @(negedge clk); s = 2'b11; pin = 4'b1010;
    @(posedge clk); #1 chk("load_1010", q, 4'b1010);
    #10 clear = 1'b0;
    #1 chk("async_clear", q, 4'b0000);

    // Shift right from zero.
    @(negedge clk); clear = 1'b1; s = 2'b01; sisr = 1'b1; sisl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 chk("shift_right", q, shr_exp[i]);
    end
    @(negedge clk); sisr = 1'b0;
    @(posedge clk); #1 chk("shift_right_zero", q, 4'b0111);

    // Shift left from zero, after a short clear pulse.
    @(negedge clk); clear = 1'b0;
    #1 chk("clear_pulse", q, 4'b0000);
    clear = 1'b1; s = 2'b10; sisl = 1'b1; sisr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 chk("shift_left", q, shl_exp[i]);
    end
    @(negedge clk); sisl = 1'b0;
    @(posedge clk); #1 chk("shift_left_zero", q, 4'b1110);

    // Unused serial input toggling: sisl during shift right.
    @(negedge clk); s = 2'b01; sisr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sisl = ~sisl;
      e = 4'b1110;
      e = e >> (i + 1);
      @(posedge clk); #1 chk("shr_ignores_sisl", q, e);
      @(negedge clk);
    end

    // Unused serial input toggling: sisr during shift left.
    s = 2'b11; pin = 4'b0101;
    @(posedge clk); #1 chk("load_0101", q, 4'b0101);
    @(negedge clk); s = 2'b10; sisl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sisr = ~sisr;
      e = 4'b0101;
      e = e << (i + 1);
      @(posedge clk); #1 chk("shl_ignores_sisr", q, e);
      @(negedge clk);
    end

    // Unknown mode select holds.
    s = 2'bxx;
    repeat (2) @(posedge clk);

    // Mode cycling off the clock grid, starting from zero.
    @(negedge clk); clear = 1'b0;
    #1 chk("cycle_start_clear", q, 4'b0000);
    clear = 1'b1;
    #9;
    for (int j = 0; j < 16; j++) begin
      s    = 2'(j % 4);
      pin  = W'($urandom);
      sisr = 1'($urandom);
      sisl = 1'($urandom);
      #100;
    end

    // Fully random traffic with occasional reset cycles.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      clear = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      s     = 2'($urandom);
      pin   = W'($urandom);
      sisr  = 1'($urandom);
      sisl  = 1'($urandom);
    end
    @(negedge clk); clear = 1'b1; s = 2'b00;
    repeat (2) @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
